// File: rtl/alu_regfile_unit.sv
// alu_regfile_unit: register file plus ALU behind a two-stage valid/ready pipeline.
// S1 latches the command; S2 holds the result until the consumer takes it.
// Operands are read as S1 advances, with forwarding from the S2 result retiring
// in the same cycle. Writeback and flag updates happen when S2 retires.
// Optional feature macro: ALU_FLAGS_EN (zero/carry flag registers).
module alu_regfile_unit #(
  parameter int  DATA_WIDTH = 8,
  parameter int  NUM_REGS   = 16,
  localparam int RW         = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [RW-1:0]         cmd_rd,
  input  logic [RW-1:0]         cmd_ra,
  input  logic [RW-1:0]         cmd_rb,
  input  logic [DATA_WIDTH-1:0] cmd_imm,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  flag_zero,
  output logic                  flag_carry,
  output logic                  busy
);
  localparam int STAGES = 2;

  typedef enum logic [2:0] {
    OP_READ, OP_WRITE, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP
  } op_e;

  typedef struct packed {
    op_e                   op;
    logic [RW-1:0]         rd;
    logic [RW-1:0]         ra;
    logic [RW-1:0]         rb;
    logic [DATA_WIDTH-1:0] imm;
  } req_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [RW-1:0]         rd;
    logic                  wb;
`ifdef ALU_FLAGS_EN
    logic                  fl_upd;
    logic                  zero;
    logic                  carry;
`endif
  } rsp_t;

  logic [STAGES:1]       vld_pipe;   // [1] = S1 occupied, [2] = S2 occupied
  req_t                  req, s1;
  rsp_t                  s2, s2_nxt;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] op_a, op_b;
  logic                  s2_retire, s1_adv, cmd_fire, fwd_en;

  assign req = '{op: op_e'(cmd_op), rd: cmd_rd, ra: cmd_ra, rb: cmd_rb, imm: cmd_imm};

  assign s2_retire = vld_pipe[2] & rsp_ready;
  assign s1_adv    = vld_pipe[1] & (~vld_pipe[2] | rsp_ready);
  assign cmd_ready = ~vld_pipe[1] | s1_adv;
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign rsp_valid = vld_pipe[2];
  assign rsp_data  = s2.data;
  assign busy      = |vld_pipe;

  // The register write of a retiring S2 op lands on the same edge S1 reads, so bypass it
  assign fwd_en = s2_retire & s2.wb;
  assign op_a   = (fwd_en && s2.rd == s1.ra) ? s2.data : regs[s1.ra];
  assign op_b   = (fwd_en && s2.rd == s1.rb) ? s2.data : regs[s1.rb];

  // ALU: result, writeback enable and flag values for the op leaving S1
  always_comb begin
    s2_nxt    = '0;
    s2_nxt.rd = s1.rd;
    unique case (s1.op)
      OP_READ:  s2_nxt.data = op_a;
      OP_WRITE: begin s2_nxt.data = s1.imm;      s2_nxt.wb = 1'b1; end
      OP_ADD:   begin s2_nxt.data = op_a + op_b; s2_nxt.wb = 1'b1; end
      OP_SUB:   begin s2_nxt.data = op_a - op_b; s2_nxt.wb = 1'b1; end
      OP_AND:   begin s2_nxt.data = op_a & op_b; s2_nxt.wb = 1'b1; end
      OP_OR:    begin s2_nxt.data = op_a | op_b; s2_nxt.wb = 1'b1; end
      OP_XOR:   begin s2_nxt.data = op_a ^ op_b; s2_nxt.wb = 1'b1; end
      OP_CMP:   s2_nxt.data = op_a - op_b;
      default:  ;
    endcase
`ifdef ALU_FLAGS_EN
    s2_nxt.fl_upd = (s1.op != OP_READ) && (s1.op != OP_WRITE);
    s2_nxt.zero   = (s2_nxt.data == '0);
    // A modular sum smaller than an addend means the add wrapped
    if (s1.op == OP_ADD)
      s2_nxt.carry = (s2_nxt.data < op_a);
    else if (s1.op == OP_SUB || s1.op == OP_CMP)
      s2_nxt.carry = (op_a < op_b);
    else
      s2_nxt.carry = 1'b0;
`endif
  end

  // Pipeline stages, valid bits and register-file writeback on retire
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (cmd_fire) s1 <= req;
      if (s1_adv)   s2 <= s2_nxt;
      vld_pipe[1] <= cmd_fire | (vld_pipe[1] & ~s1_adv);
      vld_pipe[2] <= s1_adv   | (vld_pipe[2] & ~s2_retire);
      if (s2_retire && s2.wb) regs[s2.rd] <= s2.data;
    end
  end

`ifdef ALU_FLAGS_EN
  logic zero_q, carry_q;

  // Flags follow the last retired arithmetic/logic/compare op
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (s2_retire && s2.fl_upd) begin
      zero_q  <= s2.zero;
      carry_q <= s2.carry;
    end
  end

  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
`else
  assign flag_zero  = 1'b0;
  assign flag_carry = 1'b0;
`endif

endmodule

// File: tb/tb_alu_regfile_unit.sv
// tb_alu_regfile_unit: directed literal checks plus randomized traffic, all
// compared every cycle against an in-order sequential model of the unit.
module tb_alu_regfile_unit;
  localparam int DW = 8;
  localparam int NR = 16;
  localparam int RW = 4;
`ifdef ALU_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic          clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, rsp_ready = 1'b1;
  logic [2:0]    cmd_op = '0;
  logic [RW-1:0] cmd_rd = '0, cmd_ra = '0, cmd_rb = '0;
  logic [DW-1:0] cmd_imm = '0;
  logic          cmd_ready, rsp_valid, flag_zero, flag_carry, busy;
  logic [DW-1:0] rsp_data;

  alu_regfile_unit #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_imm(cmd_imm), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .flag_zero(flag_zero), .flag_carry(flag_carry), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [2:0]    op;
    int            rd, ra, rb;
    logic [DW-1:0] imm;
    int            cyc;
  } mcmd_t;

  mcmd_t         q[$];
  logic [DW-1:0] m_regs [NR];
  bit            m_z, m_c, m_init, rr_rand;
  logic [DW-1:0] last_data;
  logic [DW-1:0] ret_log[$];
  int            ret_cyc[$], acc_cyc[$];
  int            cyc, nvec, nerr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Executes a command against the current architectural register state
  function automatic void exec(input mcmd_t c, output logic [DW-1:0] res,
                               output bit wb, output bit fu, output bit cy);
    int a, b;
    a = m_regs[c.ra];
    b = m_regs[c.rb];
    wb = 1'b0; fu = 1'b1; cy = 1'b0; res = '0;
    case (c.op)
      3'd0: begin res = DW'(a); fu = 1'b0; end
      3'd1: begin res = c.imm; wb = 1'b1; fu = 1'b0; end
      3'd2: begin res = DW'(a + b); wb = 1'b1; cy = (a + b) >= (1 << DW); end
      3'd3: begin res = DW'(a - b); wb = 1'b1; cy = a < b; end
      3'd4: begin res = DW'(a & b); wb = 1'b1; end
      3'd5: begin res = DW'(a | b); wb = 1'b1; end
      3'd6: begin res = DW'(a ^ b); wb = 1'b1; end
      default: begin res = DW'(a - b); cy = a < b; end
    endcase
  endfunction

  // Compare outputs, then advance the model with this cycle's handshakes
  initial forever begin
    logic [DW-1:0] r;
    bit wb, fu, cy, vexp, rexp;
    @(negedge clk);
    vexp = 1'b0; rexp = 1'b0;
    if (m_init) begin
      vexp = q.size() > 0 && q[0].cyc + 2 <= cyc;
      rexp = q.size() < 2 || rsp_ready;
      chk("cmd_ready", cmd_ready, rexp);
      chk("rsp_valid", rsp_valid, vexp);
      chk("busy", busy, q.size() > 0);
      if (vexp) begin
        exec(q[0], r, wb, fu, cy);
        chk("rsp_data", rsp_data, r);
      end else
        chk("rsp_data_hold", rsp_data, last_data);
      chk("flag_zero", flag_zero, FL ? m_z : 1'b0);
      chk("flag_carry", flag_carry, FL ? m_c : 1'b0);
    end
    if (reset) begin
      q.delete();
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      m_z = 1'b0; m_c = 1'b0; last_data = '0; m_init = 1'b1;
    end else if (m_init) begin
      if (vexp && rsp_ready) begin
        exec(q[0], r, wb, fu, cy);
        if (wb) m_regs[q[0].rd] = r;
        if (fu) begin m_z = (r == '0); m_c = cy; end
        last_data = r;
        ret_log.push_back(r);
        ret_cyc.push_back(cyc);
        void'(q.pop_front());
      end
      if (cmd_valid && rexp) begin
        q.push_back('{op: cmd_op, rd: int'(cmd_rd), ra: int'(cmd_ra), rb: int'(cmd_rb),
                      imm: cmd_imm, cyc: cyc});
        acc_cyc.push_back(cyc);
      end
    end
    cyc++;
  end

  // Random back-pressure, applied after the main thread's posedge+1 updates
  initial forever begin
    @(posedge clk); #2;
    if (rr_rand) rsp_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_cmd(input logic [2:0] op, input int rd, input int ra, input int rb,
                         input logic [DW-1:0] imm);
    cmd_valid = 1'b1; cmd_op = op;
    cmd_rd = RW'(rd); cmd_ra = RW'(ra); cmd_rb = RW'(rb); cmd_imm = imm;
  endtask

  task automatic issue(input logic [2:0] op, input int rd, input int ra, input int rb,
                       input logic [DW-1:0] imm);
    bit fire;
    int n;
    fire = 1'b0; n = 0;
    set_cmd(op, rd, ra, rb, imm);
    while (!fire) begin
      @(negedge clk);
      fire = cmd_ready && !reset;
      @(posedge clk); #1;
      n++;
      if (!fire && n > 100) begin
        nvec++; nerr++;
        $display("FAIL issue_timeout: got no accept expected accept within 100 cycles");
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin
      nvec++; nerr++;
      $display("FAIL drain_timeout: got busy expected idle within 200 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ret_log.delete(); ret_cyc.delete(); acc_cyc.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] hd;
    bit held;
    int acc, k;
    logic [DW-1:0] imms [3];
    imms[0] = 8'h11; imms[1] = 8'h22; imms[2] = 8'h33;
    nvec = 0; nerr = 0; cyc = 0; m_init = 1'b0; rr_rand = 1'b0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_rsp_data", rsp_data, 8'h00);
    chk("reset_cmd_ready", cmd_ready, 1'b1);
    chk("reset_flags", {flag_zero, flag_carry}, 2'b00);

    // write then read back, second response two cycles after its accept
    issue(3'd1, 3, 0, 0, 8'h5A);
    issue(3'd0, 0, 3, 0, 8'h00);
    drain();
    chk("wr_rd_0", ret_log[0], 8'h5A);
    chk("wr_rd_1", ret_log[1], 8'h5A);
    chk("wr_rd_latency", ret_cyc[1] - acc_cyc[1], 2);

    // add with carry-out
    do_reset();
    issue(3'd1, 1, 0, 0, 8'hF0);
    issue(3'd1, 2, 0, 0, 8'h20);
    issue(3'd2, 4, 1, 2, 8'h00);
    drain();
    chk("add_rsp", ret_log[2], 8'h10);
    chk("add_carry", flag_carry, FL);
    chk("add_zero", flag_zero, 1'b0);
    issue(3'd0, 0, 4, 0, 8'h00);
    drain();
    chk("add_r4", ret_log[3], 8'h10);

    // compare of a register with itself: zero result, no writeback
    do_reset();
    issue(3'd1, 1, 0, 0, 8'h05);
    issue(3'd7, 1, 1, 1, 8'h00);
    issue(3'd0, 0, 1, 0, 8'h00);
    drain();
    chk("cmp_rsp", ret_log[1], 8'h00);
    chk("cmp_r1_kept", ret_log[2], 8'h05);
    chk("cmp_zero", flag_zero, FL);
    chk("cmp_carry", flag_carry, 1'b0);

    // back-to-back dependent ops through the forward path
    do_reset();
    rsp_ready = 1'b1;
    issue(3'd1, 2, 0, 0, 8'h07);
    issue(3'd2, 5, 2, 2, 8'h00);
    drain();
    chk("fwd_rsp", ret_log[1], 8'd14);
    chk("fwd_acc_gap", acc_cyc[1] - acc_cyc[0], 1);
    chk("fwd_ret_gap", ret_cyc[1] - ret_cyc[0], 1);

    // consumer stall with three commands offered
    do_reset();
    rsp_ready = 1'b0; acc = 0; k = 0; held = 1'b0; hd = '0;
    set_cmd(3'd1, 8, 0, 0, imms[0]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cmd_ready) begin acc++; k++; end
      if (i == 4) chk("stall_cmd_ready", cmd_ready, 1'b0);
      if (rsp_valid) begin
        if (!held) begin hd = rsp_data; held = 1'b1; end
        else chk("stall_rsp_stable", rsp_data, hd);
      end
      @(posedge clk); #1;
      if (k < 3) set_cmd(3'd1, 8 + k, 0, 0, imms[k]);
    end
    chk("stall_accepted", acc, 2);
    rsp_ready = 1'b1;
    issue(3'd1, 10, 0, 0, imms[2]);
    drain();
    chk("stall_order_0", ret_log[0], 8'h11);
    chk("stall_order_1", ret_log[1], 8'h22);
    chk("stall_order_2", ret_log[2], 8'h33);

    // reset while both stages are full
    do_reset();
    rsp_ready = 1'b0;
    issue(3'd1, 11, 0, 0, 8'h44);
    issue(3'd1, 12, 0, 0, 8'h55);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    ret_log.delete();
    rsp_ready = 1'b1;
    issue(3'd0, 0, 11, 0, 8'h00);
    issue(3'd0, 0, 12, 0, 8'h00);
    drain();
    chk("rst_mid_r11", ret_log[0], 8'h00);
    chk("rst_mid_r12", ret_log[1], 8'h00);

    // randomized traffic with back-pressure; narrow index range stresses hazards
    rr_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      int hi;
      hi = ($urandom_range(0, 3) == 0) ? NR - 1 : 3;
      if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
      issue(3'($urandom_range(0, 7)), $urandom_range(0, hi), $urandom_range(0, hi),
            $urandom_range(0, hi), DW'($urandom));
    end
    rr_rand = 1'b0;
    rsp_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
